// File: rtl/alu_flag_pkg.sv
// rtl/alu_flag_pkg.sv - shared types and constants for the ALU carry/flag stage
//
// Purpose: state encoding for the multi-byte chain sequencer and bit positions
// of the flags inside the {SIGN, ZERO, CARRY} bus word.
// Ports: none (package).

package alu_flag_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_e;

  // Bit positions inside FLAGDIN
  localparam int FLAG_CY = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;

endpackage

// File: rtl/alu_carry_flags.sv
// rtl/alu_carry_flags.sv - carry/zero/sign flag register with multi-byte chaining
//
// Purpose: registers carry, zero and sign from each 8-bit ALU result, feeds the
// carry back to the carry-in mux, and sequences multi-precision operations so
// ZERO reflects the whole word. Flags can also be loaded from the bus and the
// carry can be forced set/clear.
// Ports:
//   CLK, RESETL           clock and asynchronous active-low reset
//   ALU_EN, RESULT,       ALU byte valid, result byte, carry-out and
//   CARRYOUT, LAST        end-of-operation marker
//   FLAGLD, FLAGDIN       direct flag load {SIGN, ZERO, CARRY}
//   SETCY, CLRCY          forced carry set / clear (clear wins)
//   CARRY, ZERO, SIGN     registered flags
//   BUSY                  chained operation in progress
//   DONE, CHAIN_ERR       one-cycle pulses: flags valid / chain cut at MAX_BYTES

module alu_carry_flags
  import alu_flag_pkg::*;
#(
  parameter int MAX_BYTES = 4
) (
  input  logic       CLK,
  input  logic       RESETL,
  input  logic       ALU_EN,
  input  logic [7:0] RESULT,
  input  logic       CARRYOUT,
  input  logic       LAST,
  input  logic       FLAGLD,
  input  logic [2:0] FLAGDIN,
  input  logic       SETCY,
  input  logic       CLRCY,
  output logic       CARRY,
  output logic       ZERO,
  output logic       SIGN,
  output logic       BUSY,
  output logic       DONE,
  output logic       CHAIN_ERR
);

  localparam int CW = $clog2(MAX_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zacc_q, zacc_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          sign_q, sign_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic res_zero;
  assign res_zero = (RESULT == 8'h00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (FLAGLD) begin
      // Bus load overrides everything and abandons any partial chain.
      sign_d  = FLAGDIN[FLAG_N];
      zero_d  = FLAGDIN[FLAG_Z];
      carry_d = FLAGDIN[FLAG_CY];
      state_d = ST_IDLE;
      cnt_d   = '0;
      zacc_d  = 1'b1;
    end else begin
      if (ALU_EN) begin
        carry_d = CARRYOUT;
        unique case (state_q)
          ST_IDLE: begin
            if (LAST) begin
              zero_d = res_zero;
              sign_d = RESULT[7];
              done_d = 1'b1;
            end else begin
              zacc_d  = res_zero;
              cnt_d   = CW'(1);
              state_d = ST_CHAIN;
            end
          end
          ST_CHAIN: begin
            // The byte at CNT_LAST closes the chain even without LAST.
            if (LAST || (cnt_q == CNT_LAST)) begin
              zero_d  = zacc_q & res_zero;
              sign_d  = RESULT[7];
              done_d  = 1'b1;
              err_d   = ~LAST;
              cnt_d   = '0;
              zacc_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              zacc_d = zacc_q & res_zero;
              cnt_d  = cnt_q + CW'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      // Forced carry replaces only the carry; the ALU byte still sequences.
      if (CLRCY) begin
        carry_d = 1'b0;
      end else if (SETCY) begin
        carry_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      zacc_q  <= 1'b1;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign SIGN      = sign_q;
  assign BUSY      = (state_q == ST_CHAIN);
  assign DONE      = done_q;
  assign CHAIN_ERR = err_q;

endmodule

// File: tb/tb_alu_carry_flags.sv
// tb/tb_alu_carry_flags.sv - self-checking bench for alu_carry_flags

module tb_alu_carry_flags;

  logic       CLK = 1'b0;
  logic       RESETL = 1'b0;
  logic       ALU_EN = 1'b0;
  logic [7:0] RESULT = 8'h00;
  logic       CARRYOUT = 1'b0;
  logic       LAST = 1'b0;
  logic       FLAGLD = 1'b0;
  logic [2:0] FLAGDIN = 3'b000;
  logic       SETCY = 1'b0;
  logic       CLRCY = 1'b0;
  logic       CARRY, ZERO, SIGN, BUSY, DONE, CHAIN_ERR;

  int checks = 0;
  int errors = 0;

  // Expected output words {CARRY, ZERO, SIGN, BUSY, DONE, CHAIN_ERR}
  logic [5:0] exp_q[$];

  typedef struct packed {
    logic       en;
    logic [7:0] res;
    logic       cy;
    logic       last;
    logic       fld;
    logic [2:0] fdin;
    logic       scy;
    logic       ccy;
    logic [5:0] exp;
  } vec_t;

  alu_carry_flags #(.MAX_BYTES(4)) dut (
    .CLK(CLK), .RESETL(RESETL), .ALU_EN(ALU_EN), .RESULT(RESULT),
    .CARRYOUT(CARRYOUT), .LAST(LAST), .FLAGLD(FLAGLD), .FLAGDIN(FLAGDIN),
    .SETCY(SETCY), .CLRCY(CLRCY), .CARRY(CARRY), .ZERO(ZERO), .SIGN(SIGN),
    .BUSY(BUSY), .DONE(DONE), .CHAIN_ERR(CHAIN_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] observed();
    return {CARRY, ZERO, SIGN, BUSY, DONE, CHAIN_ERR};
  endfunction

  // Drives one cycle of stimulus, queues its expectation, samples after the edge.
  task automatic apply(input vec_t v, output logic [5:0] got, output logic [5:0] want);
    ALU_EN   = v.en;
    RESULT   = v.res;
    CARRYOUT = v.cy;
    LAST     = v.last;
    FLAGLD   = v.fld;
    FLAGDIN  = v.fdin;
    SETCY    = v.scy;
    CLRCY    = v.ccy;
    exp_q.push_back(v.exp);
    @(posedge CLK);
    #1;
    got  = observed();
    want = exp_q.pop_front();
    ALU_EN = 1'b0; FLAGLD = 1'b0; SETCY = 1'b0; CLRCY = 1'b0; LAST = 1'b0;
  endtask

  function automatic vec_t idle(input logic [5:0] e);
    return '{en: 1'b0, res: 8'h00, cy: 1'b0, last: 1'b0, fld: 1'b0,
             fdin: 3'b000, scy: 1'b0, ccy: 1'b0, exp: e};
  endfunction

  function automatic vec_t alu(input logic [7:0] r, input logic c, input logic l,
                               input logic [5:0] e);
    return '{en: 1'b1, res: r, cy: c, last: l, fld: 1'b0,
             fdin: 3'b000, scy: 1'b0, ccy: 1'b0, exp: e};
  endfunction

  task automatic test_reset();
    logic [5:0] got, want;
    #2;
    exp_q.push_back(6'b000000);
    got = observed();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", got, want);
    end
    @(negedge CLK);
    RESETL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(idle(6'b000000), got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_single();
    logic [5:0] got, want;
    vec_t v [2];
    v[0] = alu(8'h00, 1'b1, 1'b1, 6'b110010);
    v[1] = idle(6'b110000);
    for (int i = 0; i < 2; i++) begin
      apply(v[i], got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_chain();
    logic [5:0] got, want;
    vec_t v [8];
    v[0] = alu(8'h00, 1'b1, 1'b0, 6'b110100);  // ZERO/SIGN held from prior op
    v[1] = alu(8'h80, 1'b0, 1'b1, 6'b001010);
    v[2] = idle(6'b001000);
    v[3] = alu(8'h00, 1'b0, 1'b0, 6'b001100);
    v[4] = idle(6'b001100);                    // stall
    v[5] = idle(6'b001100);                    // stall
    v[6] = alu(8'h00, 1'b0, 1'b0, 6'b001100);
    v[7] = alu(8'h00, 1'b0, 1'b1, 6'b010010);
    for (int i = 0; i < 8; i++) begin
      apply(v[i], got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL chain[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, want;
    vec_t v [2];
    // Issued in the cycle right after the chain's DONE
    v[0] = alu(8'h05, 1'b1, 1'b1, 6'b100010);
    v[1] = alu(8'h7F, 1'b0, 1'b1, 6'b000010);
    for (int i = 0; i < 2; i++) begin
      apply(v[i], got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_overrun();
    logic [5:0] got, want;
    vec_t v [5];
    v[0] = alu(8'h01, 1'b0, 1'b0, 6'b000100);
    v[1] = alu(8'h00, 1'b1, 1'b0, 6'b100100);
    v[2] = alu(8'h00, 1'b0, 1'b0, 6'b000100);
    v[3] = alu(8'hFF, 1'b1, 1'b0, 6'b101011);
    v[4] = idle(6'b101000);
    for (int i = 0; i < 5; i++) begin
      apply(v[i], got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL overrun[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    logic [5:0] got, want;
    vec_t v [5];
    v[0] = alu(8'h00, 1'b0, 1'b0, 6'b001100);
    v[1] = '{en: 1'b1, res: 8'h00, cy: 1'b0, last: 1'b1, fld: 1'b1,
             fdin: 3'b101, scy: 1'b1, ccy: 1'b0, exp: 6'b101000};
    v[2] = '{en: 1'b0, res: 8'h00, cy: 1'b0, last: 1'b0, fld: 1'b0,
             fdin: 3'b000, scy: 1'b1, ccy: 1'b1, exp: 6'b001000};
    v[3] = '{en: 1'b1, res: 8'h00, cy: 1'b0, last: 1'b1, fld: 1'b0,
             fdin: 3'b000, scy: 1'b1, ccy: 1'b0, exp: 6'b110010};
    v[4] = '{en: 1'b1, res: 8'h80, cy: 1'b1, last: 1'b1, fld: 1'b0,
             fdin: 3'b000, scy: 1'b0, ccy: 1'b1, exp: 6'b001010};
    for (int i = 0; i < 5; i++) begin
      apply(v[i], got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL priority[%0d]: got %b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_chain();
    logic [5:0] got, want;
    apply(alu(8'h00, 1'b1, 1'b0, 6'b101100), got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL midrst_byte0: got %b expected %b", got, want);
    end
    #2;
    RESETL = 1'b0;
    exp_q.push_back(6'b000000);
    #1;
    got = observed();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL midrst_async: got %b expected %b", got, want);
    end
    @(negedge CLK);
    RESETL = 1'b1;
    apply(alu(8'h80, 1'b1, 1'b1, 6'b101010), got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL midrst_after: got %b expected %b", got, want);
    end
    apply(idle(6'b101000), got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL midrst_idle: got %b expected %b", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_back_to_back();
    test_overrun();
    test_priority();
    test_reset_mid_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
